// File: rtl/mips_pkg.sv
// Shared encodings for the MEM-stage load/store controller: access sizes,
// EX/MEM control bit positions and controller states.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int MEM_READ  = 1;
    localparam int MEM_WRITE = 0;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

endpackage

// File: rtl/load_align.sv
// Load lane selection: picks the byte/half addressed by addr out of a
// little-endian read word and sign- or zero-extends it to 32 bits.
module load_align
    import mips_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        zext,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: result = {{24{~zext & byte_lane[7]}}, byte_lane};
            SZ_HALF: result = {{16{~zext & half_lane[15]}}, half_lane};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: issues req/ack accesses to a variable-latency
// data memory, stalls upstream while in flight and feeds the MEM/WB register.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [1:0]  M_in,
    input  logic [1:0]  WB_in,
    input  logic [1:0]  size_in,
    input  logic        unsigned_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] wdata_in,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall_out,
    output logic        valid_out,
    output logic [1:0]  WB_out,
    output logic [31:0] sum_out,
    output logic [31:0] mem_data_out,
    output logic [4:0]  rd_out,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t            state, state_nxt;
    logic [TO_W-1:0]   to_cnt;
    logic [1:0]        wb_h, size_h;
    logic [31:0]       alu_h, result_h, aligned;
    logic [4:0]        rd_h;
    logic              zext_h, we_h, err_h;
    logic              is_mem, is_store, misalign, timed_out;
    logic [31:0]       store_wdata;
    logic [3:0]        store_be;

    assign is_mem    = valid_in & (M_in[MEM_READ] | M_in[MEM_WRITE]);
    assign is_store  = M_in[MEM_WRITE];
    assign misalign  = (size_in[1] & (alu_in[1:0] != 2'b00)) |
                       ((size_in == SZ_HALF) & alu_in[0]);
    assign timed_out = (to_cnt == TO_LIMIT);

    always_comb begin
        case (size_in)
            SZ_BYTE: begin
                store_wdata = {4{wdata_in[7:0]}};
                store_be    = 4'b0001 << alu_in[1:0];
            end
            SZ_HALF: begin
                store_wdata = {2{wdata_in[15:0]}};
                store_be    = alu_in[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_wdata = wdata_in;
                store_be    = 4'b1111;
            end
        endcase
    end

    load_align u_load_align (
        .rdata  (mem_rdata),
        .addr   (alu_h[1:0]),
        .size   (size_h),
        .zext   (zext_h),
        .result (aligned)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Outputs are forced to zero while reset is held, even in IDLE passthrough.
    always_comb begin
        state_nxt    = state;
        stall_out    = 1'b0;
        valid_out    = 1'b0;
        WB_out       = 2'b00;
        sum_out      = 32'd0;
        rd_out       = 5'd0;
        mem_data_out = 32'd0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    valid_out = valid_in;
                    WB_out    = WB_in;
                    sum_out   = alu_in;
                    rd_out    = rd_in;
                    if (is_mem && misalign) begin
                        WB_out       = 2'b00;
                        misalign_err = 1'b1;
                    end else if (is_mem) begin
                        stall_out = 1'b1;
                        valid_out = 1'b0;
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    stall_out = 1'b1;
                    if (mem_ack || timed_out) state_nxt = DONE;
                end
                DONE: begin
                    valid_out    = 1'b1;
                    WB_out       = err_h ? 2'b00 : wb_h;
                    sum_out      = alu_h;
                    rd_out       = rd_h;
                    mem_data_out = result_h;
                    bus_err      = err_h;
                    state_nxt    = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Issue captures the access; WAIT tracks ack/timeout; DONE just presents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt    <= '0;
            wb_h      <= 2'b00;
            size_h    <= 2'b00;
            alu_h     <= 32'd0;
            rd_h      <= 5'd0;
            zext_h    <= 1'b0;
            we_h      <= 1'b0;
            err_h     <= 1'b0;
            result_h  <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'b0000;
        end else begin
            case (state)
                IDLE: if (is_mem && !misalign) begin
                    wb_h      <= WB_in;
                    size_h    <= size_in;
                    alu_h     <= alu_in;
                    rd_h      <= rd_in;
                    zext_h    <= unsigned_in;
                    we_h      <= is_store;
                    err_h     <= 1'b0;
                    result_h  <= 32'd0;
                    to_cnt    <= '0;
                    mem_req   <= 1'b1;
                    mem_we    <= is_store;
                    mem_addr  <= {alu_in[31:2], 2'b00};
                    mem_wdata <= is_store ? store_wdata : 32'd0;
                    mem_be    <= is_store ? store_be : 4'b1111;
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        result_h <= we_h ? 32'd0 : aligned;
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        err_h   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store controller. Its outputs drive the inputs of the MEM/WB pipeline register.
- Inputs come from EX/MEM: ALU result, store data, control bits and rd.
- Runs a req/ack handshake with a variable-latency data memory and stalls the upstream pipeline while an access is in flight.
- Aligns load data into a 32-bit word and extends it (byte/half/word), and forms byte enables for stores.

Parameters:
TIMEOUT, 255, max cycles waiting for mem_ack before aborting with bus_err
TO_W, 8, width of timeout counter; must satisfy 2**TO_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted when 0)
valid_in  in  1  EX/MEM holds a live instruction
M_in  in  2  {MemRead, MemWrite}
WB_in  in  2  writeback control, passed through
size_in  in  2  00 byte, 01 half, 10 word (11 treated as word)
unsigned_in  in  1  zero-extend loads when 1
alu_in  in  32  ALU result / effective address
wdata_in  in  32  store data (rt)
rd_in  in  5  destination register
mem_req  out  1  memory request, registered
mem_we  out  1  1 = store
mem_addr  out  32  word-aligned address ({alu[31:2],2'b00})
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_ack  in  1  one-cycle completion pulse
mem_rdata  in  32  read word, valid with mem_ack
stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
valid_out  out  1  to MEM/WB
WB_out  out  2  to MEM/WB
sum_out  out  32  to MEM/WB (ALU result)
mem_data_out  out  32  to MEM/WB (extended load data)
rd_out  out  5  to MEM/WB
misalign_err  out  1  one-cycle pulse
bus_err  out  1  one-cycle pulse

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; all registers clear.
  - mem_req, mem_we, mem_be, stall_out, valid_out, misalign_err, bus_err = 0.
  - All data outputs = 0.
  - Reset mid-WAIT drops mem_req immediately. A later mem_ack in IDLE is ignored.
- States IDLE, WAIT, DONE.
- mem = valid_in & (MemRead|MemWrite). MemRead and MemWrite both 1 is treated as a store.
- IDLE, no mem (or valid_in=0):
  - Combinational passthrough to MEM/WB: valid_out=valid_in, WB_out=WB_in, sum_out=alu_in, rd_out=rd_in, mem_data_out=0.
  - stall_out=0.
- IDLE, mem, misaligned (word with alu[1:0]!=0, or half with alu[0]!=0):
  - No request is issued.
  - Same cycle: valid_out=1, WB_out=00 (write suppressed), misalign_err=1, stall_out=0.
- IDLE, mem, aligned:
  - Same cycle: stall_out=1, valid_out=0 (bubble).
  - Capture WB/alu/rd/size/unsigned/we into hold registers.
  - Next edge: state=WAIT, mem_req=1, timeout counter=0.
- WAIT:
  - stall_out=1, valid_out=0.
  - mem_req, mem_addr, mem_we, mem_be, mem_wdata held stable until the ack cycle.
  - Counter increments each cycle without ack.
  - On mem_ack: load extended data into result register; mem_req=0 next edge; state=DONE.
  - On counter==TIMEOUT with no ack: mem_req=0, state=DONE with error flag.
  - If mem_ack and timeout coincide, the ack wins.
- DONE (exactly one cycle):
  - stall_out=0, valid_out=1; held fields on outputs; mem_data_out = result register.
  - On error: WB_out=00 and bus_err=1.
  - Next edge: IDLE. A new instruction is not examined in DONE; it is examined in the following IDLE cycle.
  - Minimum memory-op latency: issue cycle + ≥1 WAIT + DONE = 3 cycles with ack on the first WAIT cycle.
- Store lanes:
  - Byte: mem_wdata={4{wdata[7:0]}}, mem_be=4'b0001<<alu[1:0].
  - Half: mem_wdata={2{wdata[15:0]}}, mem_be = 0011 if alu[1]=0, 1100 if alu[1]=1.
  - Word: mem_wdata=wdata_in, mem_be=1111.
- Loads:
  - mem_be=1111.
  - Extract the lane selected by alu[1:0] (byte) or alu[1] (half); little-endian.
  - Sign-extend unless unsigned_in. Store mem_data_out=0.

Decomposition:
- Shared package mips_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state enum {IDLE,WAIT,DONE}
  - M-bit index constants MEM_READ=1, MEM_WRITE=0
- One sub-module, load_align: combinational lane select plus sign/zero extend from (rdata, addr[1:0], size, unsigned) to a 32-bit result. It is unit-testable on its own.

Test Plan:
- Word load at alu=0x100, ack after 2 WAIT cycles, rdata=0xDEADBEEF -> mem_addr=0x100, mem_be=1111; stall high 4 cycles (issue + 2 WAIT + ack cycle); DONE cycle valid_out=1, mem_data_out=0xDEADBEEF, sum_out=0x100.
- Signed byte load at alu=0x103, rdata=0x80FFFFFF, then unsigned repeat -> mem_data_out=0xFFFFFF80 signed, 0x00000080 unsigned.
- Half store at alu=0x22, wdata=0x1234ABCD -> mem_addr=0x20, mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1; DONE valid_out=1, mem_data_out=0.
- Word load at alu=0x102 -> no mem_req; same-cycle misalign_err=1, valid_out=1, WB_out=00, stall_out=0.
- TIMEOUT=4, no ack -> mem_req high 5 cycles, then bus_err=1, WB_out=00 in DONE; back-to-back ALU op afterwards passes through unstalled.
- rst=0 asserted in WAIT, ack arrives 1 cycle after release -> mem_req=0 immediately; ack ignored, no valid_out, state IDLE.
